// File: rtl/pll_dyn_ctrl.sv
// pll_dyn_ctrl: runtime divider reconfiguration for a dynamic rPLL.
// Applies presets, sequences PLL reset, waits for lock, retries, watches loss.
module pll_dyn_ctrl #(
  parameter int NUM_MODES = 4,
  parameter int INIT_MODE = 0,
  parameter logic [6*NUM_MODES-1:0] MODE_IDIV =
    {6'd8, 6'd8, 6'd3, 6'd8},
  parameter logic [6*NUM_MODES-1:0] MODE_FBDIV =
    {6'd15, 6'd15, 6'd36, 6'd15},
  parameter logic [6*NUM_MODES-1:0] MODE_ODSEL =
    {6'd56, 6'd56, 6'd60, 6'd56},
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int MAX_RETRIES = 3,
  localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic          clkin,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [MW-1:0] req_mode,
  output logic          req_ready,
  input  logic          pll_lock,
  output logic          pll_reset,
  output logic [5:0]    idsel,
  output logic [5:0]    fbdsel,
  output logic [5:0]    odsel,
  output logic          locked,
  output logic          busy,
  output logic          fault,
  output logic [MW-1:0] cur_mode,
  output logic          bad_mode,
  output logic [7:0]    relock_count
);

  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int MW1 = MW + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0] RET_MAX = RW'(MAX_RETRIES);
  localparam logic [MW1-1:0] NM = MW1'(NUM_MODES);
  localparam logic [MW-1:0] INIT_M = MW'(INIT_MODE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_RST_HOLD,
    S_LOCK_WAIT,
    S_LOCKED,
    S_FAULT
  } state_t;

  state_t state, state_n;

  logic          lk_meta, lk;
  logic [1:0]    lk_cnt;
  logic          loss_cnt;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] to_cnt;
  logic [RW-1:0] retries;

  logic mode_ok, accept, reject, loss, lock_ok;
  logic to_retry, to_fault, hold_done;

  function automatic logic [5:0] pick(
    input logic [6*NUM_MODES-1:0] tbl,
    input logic [MW-1:0]          m
  );
    logic [5:0] v;
    v = '0;
    for (int i = 0; i < NUM_MODES; i++)
      if (m == MW'(i)) v = tbl[6*i +: 6];
    return v;
  endfunction

  assign mode_ok = ({1'b0, req_mode} < NM);

  // Bring the asynchronous PLL lock into the clkin domain.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
    end else begin
      lk_meta <= pll_lock;
      lk      <= lk_meta;
    end
  end

  // State register.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) state <= S_RST_HOLD;
    else       state <= state_n;
  end

  // Next-state decode and per-cycle event flags.
  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    loss      = 1'b0;
    lock_ok   = 1'b0;
    to_retry  = 1'b0;
    to_fault  = 1'b0;
    hold_done = 1'b0;
    unique case (state)
      S_APPLY: state_n = S_RST_HOLD;
      S_RST_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          hold_done = 1'b1;
          state_n   = S_LOCK_WAIT;
        end
      end
      S_LOCK_WAIT: begin
        if (lk && lk_cnt == 2'd3) begin
          lock_ok = 1'b1;
          state_n = S_LOCKED;
        end else if (to_cnt == TO_LAST) begin
          if (retries < RET_MAX) begin
            to_retry = 1'b1;
            state_n  = S_APPLY;
          end else begin
            to_fault = 1'b1;
            state_n  = S_FAULT;
          end
        end
      end
      S_LOCKED: begin
        req_ready = 1'b1;
        loss      = !lk && loss_cnt;
        if (loss) state_n = S_APPLY;
      end
      default: req_ready = 1'b1;
    endcase
    if (req_ready && req_valid) begin
      if (mode_ok) begin
        accept  = 1'b1;
        state_n = S_APPLY;
      end else begin
        reject = 1'b1;
      end
    end
  end

  // Datapath: divider selects, counters and status outputs.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      pll_reset    <= 1'b1;
      locked       <= 1'b0;
      busy         <= 1'b1;
      fault        <= 1'b0;
      bad_mode     <= 1'b0;
      relock_count <= 8'd0;
      cur_mode     <= INIT_M;
      idsel        <= 6'd63 - pick(MODE_IDIV, INIT_M);
      fbdsel       <= 6'd63 - pick(MODE_FBDIV, INIT_M);
      odsel        <= pick(MODE_ODSEL, INIT_M);
      // pll_reset is already high during reset, so one hold cycle is done.
      hold_cnt     <= HW'(1);
      to_cnt       <= '0;
      lk_cnt       <= 2'd0;
      loss_cnt     <= 1'b0;
      retries      <= '0;
    end else begin
      bad_mode <= reject;
      case (state)
        S_APPLY: begin
          idsel    <= 6'd63 - pick(MODE_IDIV, cur_mode);
          fbdsel   <= 6'd63 - pick(MODE_FBDIV, cur_mode);
          odsel    <= pick(MODE_ODSEL, cur_mode);
          hold_cnt <= '0;
        end
        S_RST_HOLD: begin
          pll_reset <= !hold_done;
          hold_cnt  <= hold_cnt + 1'b1;
          to_cnt    <= '0;
          lk_cnt    <= 2'd0;
        end
        S_LOCK_WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          lk_cnt <= lk ? lk_cnt + 2'd1 : 2'd0;
          if (lock_ok) begin
            locked   <= 1'b1;
            busy     <= 1'b0;
            retries  <= '0;
            loss_cnt <= 1'b0;
          end
          if (to_retry) retries <= retries + 1'b1;
          if (to_fault) begin
            fault     <= 1'b1;
            busy      <= 1'b0;
            pll_reset <= 1'b1;
          end
        end
        S_LOCKED: begin
          loss_cnt <= !lk;
          if (loss) begin
            locked  <= 1'b0;
            busy    <= 1'b1;
            retries <= '0;
            if (relock_count != 8'hff)
              relock_count <= relock_count + 8'd1;
          end
        end
        default: ;
      endcase
      if (accept) begin
        cur_mode <= req_mode;
        fault    <= 1'b0;
        retries  <= '0;
        locked   <= 1'b0;
        busy     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// tb_pll_dyn_ctrl: directed and randomized checks of pll_dyn_ctrl.
// A behavioural PLL drops lock under reset and relocks after a delay.
module tb_pll_dyn_ctrl;

  localparam int RC = 16;
  localparam int LT = 4096;
  localparam int MR = 3;
  localparam logic [23:0] T_ID = {6'd8, 6'd8, 6'd3, 6'd8};
  localparam logic [23:0] T_FB = {6'd15, 6'd15, 6'd36, 6'd15};
  localparam logic [23:0] T_OD = {6'd56, 6'd56, 6'd60, 6'd56};
  localparam logic [17:0] T3_ID = {6'd5, 6'd4, 6'd3};
  localparam logic [17:0] T3_FB = {6'd20, 6'd21, 6'd22};
  localparam logic [17:0] T3_OD = {6'd8, 6'd16, 6'd32};

  logic clkin, reset;
  logic req_valid, req_ready, pll_lock, pll_reset;
  logic [1:0] req_mode, cur_mode;
  logic [5:0] idsel, fbdsel, odsel;
  logic locked, busy, fault, bad_mode;
  logic [7:0] relock_count;

  logic req_valid3, req_ready3, lock3, pll_reset3;
  logic [1:0] req_mode3, cur_mode3;
  logic [5:0] idsel3, fbdsel3, odsel3;
  logic locked3, busy3, fault3, bad_mode3;
  logic [7:0] relock_count3;

  logic lk_model, drop, lock_en;
  int   lock_delay, lcnt;
  int   checks, errors;
  int   exp_mode, exp_relock;

  pll_dyn_ctrl #(
    .NUM_MODES(4), .INIT_MODE(0),
    .MODE_IDIV(T_ID), .MODE_FBDIV(T_FB), .MODE_ODSEL(T_OD),
    .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .MAX_RETRIES(MR)
  ) u_dut (
    .clkin(clkin), .reset(reset),
    .req_valid(req_valid), .req_mode(req_mode),
    .req_ready(req_ready), .pll_lock(pll_lock),
    .pll_reset(pll_reset), .idsel(idsel),
    .fbdsel(fbdsel), .odsel(odsel),
    .locked(locked), .busy(busy), .fault(fault),
    .cur_mode(cur_mode), .bad_mode(bad_mode),
    .relock_count(relock_count)
  );

  pll_dyn_ctrl #(
    .NUM_MODES(3), .INIT_MODE(0),
    .MODE_IDIV(T3_ID), .MODE_FBDIV(T3_FB), .MODE_ODSEL(T3_OD),
    .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .MAX_RETRIES(MR)
  ) u_dut3 (
    .clkin(clkin), .reset(reset),
    .req_valid(req_valid3), .req_mode(req_mode3),
    .req_ready(req_ready3), .pll_lock(lock3),
    .pll_reset(pll_reset3), .idsel(idsel3),
    .fbdsel(fbdsel3), .odsel(odsel3),
    .locked(locked3), .busy(busy3), .fault(fault3),
    .cur_mode(cur_mode3), .bad_mode(bad_mode3),
    .relock_count(relock_count3)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // Behavioural PLL: lock is lost under reset, regained lock_delay later.
  always @(posedge clkin) begin
    if (pll_reset || !lock_en) begin
      lk_model <= 1'b0;
      lcnt     <= 0;
    end else if (lcnt >= lock_delay) begin
      lk_model <= 1'b1;
    end else begin
      lcnt <= lcnt + 1;
    end
  end

  assign pll_lock = lk_model & ~drop;

  function automatic logic [5:0] e_id(input int m);
    return 6'd63 - T_ID[6*m +: 6];
  endfunction
  function automatic logic [5:0] e_fb(input int m);
    return 6'd63 - T_FB[6*m +: 6];
  endfunction
  function automatic logic [5:0] e_od(input int m);
    return T_OD[6*m +: 6];
  endfunction

  task automatic tick;
    @(negedge clkin);
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_sels(input string tag, input int m);
    check({tag, "_idsel"}, idsel, e_id(m));
    check({tag, "_fbdsel"}, fbdsel, e_fb(m));
    check({tag, "_odsel"}, odsel, e_od(m));
  endtask

  task automatic wait_lock_exact(input string tag);
    int n;
    n = 0;
    while (!pll_lock && n < 20000) begin
      tick;
      n++;
    end
    check({tag, "_lock_rise"}, pll_lock, 1);
    n = 0;
    while (!locked && n < 20) begin
      tick;
      n++;
    end
    check({tag, "_lock_latency"}, n, 6);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_mode"}, cur_mode, exp_mode);
  endtask

  task automatic do_req(input int m, input bit from_locked);
    int n, hi;
    bit seen;
    check("req_ready_pre", req_ready, 1);
    req_valid = 1'b1;
    req_mode  = 2'(m);
    tick;
    req_valid = 1'b0;
    exp_mode  = m;
    check("req_ready_drop", req_ready, 0);
    check("req_busy", busy, 1);
    check("req_locked_clr", locked, 0);
    check("req_fault_clr", fault, 0);
    check("req_cur_mode", cur_mode, m);
    n = 1;
    hi = 0;
    seen = 0;
    while (n < 200) begin
      if (pll_reset) begin
        if (!seen && from_locked) check_sels("rst_rise", m);
        seen = 1;
        hi++;
      end else if (seen) begin
        break;
      end
      tick;
      n++;
    end
    check("release_latency", n - 1, RC + 2);
    if (from_locked) check("rst_width", hi, RC);
    check_sels("release", m);
  endtask

  task automatic glitch(input int len);
    int n;
    bit seen_rst;
    drop = 1'b1;
    repeat (len) tick;
    drop = 1'b0;
    if (len >= 2) begin
      exp_relock = (exp_relock < 255) ? exp_relock + 1 : 255;
      n = 0;
      while (locked && n < 10) begin
        tick;
        n++;
      end
      check("loss_detect", locked, 0);
      n = 0;
      seen_rst = 0;
      while (!locked && n < 5000) begin
        tick;
        n++;
        if (pll_reset) seen_rst = 1;
      end
      check("relock", locked, 1);
      check("reapply", seen_rst, 1);
    end else begin
      repeat (10) tick;
      check("glitch_hold_lock", locked, 1);
      check("glitch_no_reset", pll_reset, 0);
    end
    check("relock_count", relock_count, exp_relock);
    check("glitch_mode", cur_mode, exp_mode);
  endtask

  initial begin
    int n, rises, m;
    logic prev;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    req_valid = 1'b0;
    req_mode = 2'd0;
    req_valid3 = 1'b0;
    req_mode3 = 2'd0;
    lock3 = 1'b1;
    lock_en = 1'b0;
    lock_delay = 100;
    drop = 1'b0;
    exp_mode = 0;
    exp_relock = 0;
    repeat (3) tick;

    check("rst_pll_reset", pll_reset, 1);
    check("rst_locked", locked, 0);
    check("rst_busy", busy, 1);
    check("rst_fault", fault, 0);
    check("rst_bad_mode", bad_mode, 0);
    check("rst_relock", relock_count, 0);
    check("rst_ready", req_ready, 0);
    check("rst_mode", cur_mode, 0);
    check_sels("rst", 0);

    lock_en = 1'b1;
    reset = 1'b0;
    n = 0;
    while (pll_reset && n < 100) begin
      tick;
      n++;
    end
    check("init_hold", n, RC);
    wait_lock_exact("init");
    check("init_ready", req_ready, 1);
    check_sels("init", 0);

    check("d3_locked", locked3, 1);
    req_valid3 = 1'b1;
    req_mode3 = 2'd3;
    tick;
    req_valid3 = 1'b0;
    check("d3_bad_pulse", bad_mode3, 1);
    tick;
    check("d3_bad_clear", bad_mode3, 0);
    check("d3_locked_kept", locked3, 1);
    check("d3_mode_kept", cur_mode3, 0);
    check("d3_idsel_kept", idsel3, 6'd63 - T3_ID[5:0]);
    check("d3_odsel_kept", odsel3, T3_OD[5:0]);
    req_valid3 = 1'b1;
    req_mode3 = 2'd2;
    tick;
    req_valid3 = 1'b0;
    check("d3_accept_mode", cur_mode3, 2);
    check("d3_accept_nobad", bad_mode3, 0);

    do_req(1, 1);
    wait_lock_exact("mode1");
    do_req(2, 1);
    wait_lock_exact("mode2");
    repeat (5) begin
      m = $urandom_range(0, 3);
      lock_delay = $urandom_range(5, 200);
      do_req(m, 1);
      wait_lock_exact("rand_mode");
    end
    do_req(exp_mode, 1);
    wait_lock_exact("same_mode");

    lock_delay = 10;
    glitch(1);
    glitch(3);
    repeat (6) glitch($urandom_range(1, 4));
    lock_delay = 3;
    repeat (300) glitch(3);
    check("relock_saturated", relock_count, 255);

    lock_en = 1'b0;
    m = $urandom_range(0, 3);
    check("fault_req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_mode = 2'(m);
    tick;
    req_valid = 1'b0;
    n = 1;
    rises = 0;
    while (!fault && n < 4 * (RC + 2 + LT) + 100) begin
      prev = pll_reset;
      tick;
      n++;
      if (pll_reset && !prev && !fault) rises++;
    end
    check("fault_time", n - 1, 4 * (RC + 2 + LT));
    check("fault_attempts", rises, 1 + MR);
    check("fault_pll_reset", pll_reset, 1);
    check("fault_busy", busy, 0);
    check("fault_locked", locked, 0);
    check("fault_ready", req_ready, 1);
    check("fault_mode", cur_mode, m);

    lock_en = 1'b1;
    lock_delay = $urandom_range(5, 100);
    do_req(0, 0);
    wait_lock_exact("fault_recover");
    check("fault_cleared", fault, 0);

    lock_en = 1'b0;
    do_req(2, 1);
    repeat (20) tick;
    check("lw_mode", cur_mode, 2);
    check("lw_locked", locked, 0);
    check("lw_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_pll_reset", pll_reset, 1);
    check("mid_busy", busy, 1);
    check("mid_locked", locked, 0);
    check("mid_fault", fault, 0);
    check("mid_ready", req_ready, 0);
    check("mid_mode", cur_mode, 0);
    check("mid_relock", relock_count, 0);
    check_sels("mid", 0);
    tick;
    exp_mode = 0;
    lock_en = 1'b1;
    lock_delay = 50;
    reset = 1'b0;
    n = 0;
    while (pll_reset && n < 100) begin
      tick;
      n++;
    end
    check("rerun_hold", n, RC);
    wait_lock_exact("rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
